river_scroll_fetch: RTL

Upstream stage of river_palette. Converts the VGA raster position into a background-ROM address and returns the 4-bit palette index for each active pixel. Scrolls the river image vertically by a per-frame speed, updated only at frame boundaries so the image never tears. river_palette consumes pix_index directly.

---
 rtl/river_pkg.sv | 18 +
 rtl/river_scroll_ctrl.sv | 60 ++++++
 rtl/river_scroll_fetch.sv | 83 ++++++++
 3 files changed

// File: rtl/river_pkg.sv
// rtl/river_pkg.sv - shared constants and types for the river scroll/palette path
package river_pkg;

    localparam int IMG_W           = 160;
    localparam int IMG_H           = 120;
    localparam int SCALE_SH        = 2;
    localparam int ADDR_W          = 15;
    localparam int RIVER_FETCH_LAT = 3;

    typedef logic [6:0] scroll_t;
    typedef logic [3:0] pal_idx_t;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } scroll_state_t;

endpackage

// File: rtl/river_scroll_ctrl.sv
// rtl/river_scroll_ctrl.sv - vsync frame tick, RUN/HOLD pause FSM and modular scroll accumulator
module river_scroll_ctrl #(
    parameter int IMG_H = river_pkg::IMG_H
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       vs_n,
    input  logic [3:0] speed,
    input  logic       pause,
    output logic [6:0] scroll_y
);
    import river_pkg::*;

    scroll_state_t state, state_next;
    scroll_t       scroll_next;
    logic          vs_prev;
    logic          frame_tick;
    logic [7:0]    sum;

    assign frame_tick = vs_prev & ~vs_n;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= RUN;
            vs_prev  <= 1'b1;
            scroll_y <= '0;
        end else begin
            state    <= state_next;
            vs_prev  <= vs_n;
            scroll_y <= scroll_next;
        end
    end

    // Pause is only honoured at frame boundaries so a frame never tears.
    always_comb begin
        state_next  = state;
        scroll_next = scroll_y;
        sum         = {1'b0, scroll_y} + {4'b0, speed};
        if (frame_tick) begin
            case (state)
                RUN: begin
                    if (pause) begin
                        state_next = HOLD;
                    end else if (sum >= 8'(IMG_H)) begin
                        scroll_next = 7'(sum - 8'(IMG_H));
                    end else begin
                        scroll_next = sum[6:0];
                    end
                end
                HOLD: begin
                    if (!pause) begin
                        state_next = RUN;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

endmodule

// File: rtl/river_scroll_fetch.sv
// rtl/river_scroll_fetch.sv - raster to background-ROM address with vertical scroll, 3-cycle fetch pipeline
// Optional column mirroring is enabled by defining RIVER_MIRROR_EN.
module river_scroll_fetch #(
    parameter int IMG_W    = river_pkg::IMG_W,
    parameter int IMG_H    = river_pkg::IMG_H,
    parameter int SCALE_SH = river_pkg::SCALE_SH,
    parameter int ADDR_W   = river_pkg::ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              de,
    input  logic              vs_n,
`ifdef RIVER_MIRROR_EN
    input  logic              mirror,
`endif
    input  logic [3:0]        speed,
    input  logic              pause,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        pix_index,
    output logic              pix_valid,
    output logic [6:0]        scroll_y
);
    import river_pkg::*;

    localparam logic [10:0] X_LIM = 11'(IMG_W << SCALE_SH);
    localparam logic [10:0] Y_LIM = 11'(IMG_H << SCALE_SH);

    logic [7:0]                 col_raw;
    logic [7:0]                 col;
    logic [7:0]                 yt;
    logic [8:0]                 diff;
    logic [8:0]                 row;
    logic [ADDR_W-1:0]          addr_next;
    logic                       v0;
    logic [RIVER_FETCH_LAT-1:0] vpipe;

    river_scroll_ctrl #(
        .IMG_H (IMG_H)
    ) u_ctrl (
        .Clk      (Clk),
        .Reset    (Reset),
        .vs_n     (vs_n),
        .speed    (speed),
        .pause    (pause),
        .scroll_y (scroll_y)
    );

    always_comb begin
        col_raw = 8'(DrawX >> SCALE_SH);
`ifdef RIVER_MIRROR_EN
        col     = mirror ? (8'(IMG_W - 1) - col_raw) : col_raw;
`else
        col     = col_raw;
`endif
        yt      = 8'(DrawY >> SCALE_SH);
        // Subtracting the offset moves image content down the screen as scroll grows.
        diff    = {1'b0, yt} - {2'b0, scroll_y};
        row     = diff[8] ? (diff + 9'(IMG_H)) : diff;
        addr_next = ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
        v0      = de & ({1'b0, DrawX} < X_LIM) & ({1'b0, DrawY} < Y_LIM);
    end

    assign pix_valid = vpipe[RIVER_FETCH_LAT-1];

    // The address is held through blanking so the ROM sees no needless activity.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr  <= '0;
            vpipe     <= '0;
            pix_index <= '0;
        end else begin
            if (v0) begin
                rom_addr <= addr_next;
            end
            vpipe     <= {vpipe[RIVER_FETCH_LAT-2:0], v0};
            pix_index <= vpipe[RIVER_FETCH_LAT-2] ? rom_data : 4'h0;
        end
    end

endmodule
